pixel_op_pipe: RTL and testbench

PIXEL_OP_PIPE -- requirements
Module: pixel_op_pipe

---
 rtl/pixel_op_pkg.sv | 26 ++
 rtl/pixel_alu.sv | 46 ++++
 rtl/pixel_op_pipe.sv | 173 +++++++++++++++++
 tb/tb_pixel_op_pipe.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pixel_op_pkg.sv
// Shared encodings for the pixel operation pipeline: modes, FSM states, beat tags.
package pixel_op_pkg;

    localparam int unsigned DW_DEFAULT = 8;

    typedef enum logic [2:0] {
        MODE_PASS = 3'd0,
        MODE_ADD  = 3'd1,
        MODE_SUB  = 3'd2,
        MODE_INV  = 3'd3,
        MODE_THR  = 3'd4
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_DRAIN  = 2'd2
    } state_e;

    typedef struct packed {
        logic sol;
        logic eol;
        logic eof;
    } tags_t;

endpackage

// File: rtl/pixel_alu.sv
// Single-pixel colour operation ({R,G,B}, B in LSBs); purely combinational.
module pixel_alu
    import pixel_op_pkg::*;
#(
    parameter int unsigned DW = DW_DEFAULT
) (
    input  logic [2:0]      mode,
    input  logic [DW-1:0]   value,
    input  logic [3*DW-1:0] pix,
    output logic [3*DW-1:0] result_c
);

    localparam int unsigned SW = DW + 2;

    logic [SW-1:0] luma_sum;
    logic [SW-1:0] thr_level;
    logic          thr_hit;
    logic [DW-1:0] chan;
    logic [DW-1:0] res;
    logic [DW:0]   add_full;

    // Threshold compares the channel sum against 3*value, both at DW+2 bits.
    assign luma_sum  = SW'(pix[0 +: DW]) + SW'(pix[DW +: DW]) + SW'(pix[2*DW +: DW]);
    assign thr_level = SW'({value, 1'b0}) + SW'(value);
    assign thr_hit   = (luma_sum >= thr_level);

    always_comb begin
        result_c = pix;
        chan     = '0;
        res      = '0;
        add_full = '0;
        for (int ch = 0; ch < 3; ch++) begin
            chan     = pix[ch*DW +: DW];
            add_full = {1'b0, chan} + {1'b0, value};
            case (mode)
                MODE_ADD: res = add_full[DW] ? '1 : add_full[DW-1:0];
                MODE_SUB: res = (chan < value) ? '0 : chan - value;
                MODE_INV: res = ~chan;
                MODE_THR: res = thr_hit ? '1 : '0;
                default:  res = chan;
            endcase
            result_c[ch*DW +: DW] = res;
        end
    end

endmodule

// File: rtl/pixel_op_pipe.sv
// Two-stage streaming pixel pipeline: S1 holds the accepted beat and operates on it,
// S2 is the output register; frame position is tracked and tagged at acceptance.
module pixel_op_pipe
    import pixel_op_pkg::*;
#(
    parameter int unsigned WIDTH  = 768,
    parameter int unsigned HEIGHT = 512,
    parameter int unsigned PPC    = 3,
    parameter int unsigned DW     = DW_DEFAULT
) (
    input  logic                clk,
    input  logic                Reset,
    input  logic [2:0]          mode,
    input  logic [DW-1:0]       value,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [PPC*3*DW-1:0] in_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [PPC*3*DW-1:0] out_data,
    output logic                out_sol,
    output logic                out_eol,
    output logic                out_eof,
    output logic                frame_done,
    output logic                busy
);

    localparam int unsigned PW    = 3 * DW;
    localparam int unsigned BW    = PPC * PW;
    localparam int unsigned BEATS = WIDTH / PPC;
    localparam int unsigned CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int unsigned RW    = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

    state_e        state;
    state_e        state_next;

    logic          s1_valid;
    logic [BW-1:0] s1_data;
    tags_t         s1_tags;
    logic          s2_valid;
    logic [BW-1:0] s2_data;
    tags_t         s2_tags;

    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic [2:0]    mode_q;
    logic [DW-1:0] value_q;
    logic          frame_done_q;
    logic          busy_q;

    logic [BW-1:0] alu_data_c;
    tags_t         tags_c;
    logic          last_col_c;
    logic          last_row_c;
    logic          first_c;
    logic          allow_c;
    logic          s2_load_c;
    logic          in_fire_c;
    logic          out_fire_c;
    logic          done_c;

    // S1 operation: one ALU per pixel of the beat, driven by the frame-latched controls.
    for (genvar k = 0; k < PPC; k++) begin : g_alu
        pixel_alu #(.DW(DW)) u_alu (
            .mode     (mode_q),
            .value    (value_q),
            .pix      (s1_data[k*PW +: PW]),
            .result_c (alu_data_c[k*PW +: PW])
        );
    end

    assign last_col_c = (col == CW'(BEATS - 1));
    assign last_row_c = (row == RW'(HEIGHT - 1));
    assign first_c    = (col == '0) && (row == '0);
    assign tags_c     = '{sol: (col == '0), eol: last_col_c, eof: last_col_c && last_row_c};

    assign allow_c    = (state != ST_DRAIN);
    assign s2_load_c  = !s2_valid || out_ready;
    assign in_ready   = allow_c && !Reset && (!s1_valid || s2_load_c);
    assign in_fire_c  = in_valid && in_ready;
    assign out_fire_c = s2_valid && out_ready;

    always_ff @(posedge clk) begin
        if (Reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        done_c     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (in_fire_c) begin
                    state_next = tags_c.eof ? ST_DRAIN : ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                if (in_fire_c && tags_c.eof) begin
                    state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (out_fire_c && s2_tags.eof) begin
                    state_next = ST_IDLE;
                    done_c     = 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Datapath, position counters and frame-latched controls.
    always_ff @(posedge clk) begin
        if (Reset) begin
            s1_valid     <= 1'b0;
            s1_data      <= '0;
            s1_tags      <= '0;
            s2_valid     <= 1'b0;
            s2_data      <= '0;
            s2_tags      <= '0;
            col          <= '0;
            row          <= '0;
            mode_q       <= MODE_PASS;
            value_q      <= '0;
            frame_done_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            frame_done_q <= done_c;
            busy_q       <= (state_next != ST_IDLE);

            if (in_fire_c) begin
                s1_valid <= 1'b1;
                s1_data  <= in_data;
                s1_tags  <= tags_c;
            end else if (s2_load_c) begin
                s1_valid <= 1'b0;
            end

            if (s2_load_c) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    s2_data <= alu_data_c;
                    s2_tags <= s1_tags;
                end
            end

            if (in_fire_c) begin
                if (first_c) begin
                    mode_q  <= mode;
                    value_q <= value;
                end
                if (last_col_c) begin
                    col <= '0;
                    row <= last_row_c ? '0 : row + RW'(1);
                end else begin
                    col <= col + CW'(1);
                end
            end
        end
    end

    assign out_valid  = s2_valid;
    assign out_data   = s2_data;
    assign out_sol    = s2_tags.sol;
    assign out_eol    = s2_tags.eol;
    assign out_eof    = s2_tags.eof;
    assign frame_done = frame_done_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_pixel_op_pipe.sv
// Randomised bench for pixel_op_pipe on a 6x2 image at 3 pixels/beat, checked
// every cycle against a frame-level reference model.
module tb_pixel_op_pipe;

    localparam int unsigned WIDTH  = 6;
    localparam int unsigned HEIGHT = 2;
    localparam int unsigned PPC    = 3;
    localparam int unsigned DW     = 8;
    localparam int unsigned BW     = PPC * 3 * DW;
    localparam int unsigned BPL    = WIDTH / PPC;
    localparam int unsigned BPF    = BPL * HEIGHT;

    logic          clk = 1'b0;
    logic          Reset;
    logic [2:0]    mode;
    logic [DW-1:0] value;
    logic          in_valid;
    logic          in_ready;
    logic [BW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [BW-1:0] out_data;
    logic          out_sol, out_eol, out_eof;
    logic          frame_done;
    logic          busy;

    pixel_op_pipe #(.WIDTH(WIDTH), .HEIGHT(HEIGHT), .PPC(PPC), .DW(DW)) dut (
        .clk        (clk),
        .Reset      (Reset),
        .mode       (mode),
        .value      (value),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_sol    (out_sol),
        .out_eol    (out_eol),
        .out_eof    (out_eof),
        .frame_done (frame_done),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [BW-1:0] data;
        logic [2:0]    tags;
        int            acc;
    } exp_t;

    exp_t          q[$];
    exp_t          e;
    int            checks   = 0;
    int            failures = 0;
    int            cyc      = 0;
    int            idx      = 0;
    int            fmode    = 0;
    int            fval     = 0;
    bit            busy_m   = 0;
    bit            drain_m  = 0;
    bit            done_m   = 0;
    bit            prev_reset = 1;
    bit            prev_stall = 0;
    logic [BW-1:0] prev_data;
    logic [2:0]    prev_tags;
    bit            ofire_eof;
    bit            lat_check = 0;
    int            rdy_mode  = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference pixel rule in plain integer arithmetic.
    function automatic logic [23:0] px_op(input int m, input int v, input logic [23:0] p);
        int c[3];
        int o[3];
        int s;
        c[2] = int'(p[23:16]);
        c[1] = int'(p[15:8]);
        c[0] = int'(p[7:0]);
        s = c[0] + c[1] + c[2];
        for (int i = 0; i < 3; i++) begin
            case (m)
                1:       o[i] = (c[i] + v > 255) ? 255 : c[i] + v;
                2:       o[i] = (c[i] - v < 0) ? 0 : c[i] - v;
                3:       o[i] = 255 - c[i];
                4:       o[i] = (s >= 3 * v) ? 255 : 0;
                default: o[i] = c[i];
            endcase
        end
        return {8'(o[2]), 8'(o[1]), 8'(o[0])};
    endfunction

    function automatic logic [BW-1:0] beat_op(input int m, input int v, input logic [BW-1:0] d);
        logic [BW-1:0] r;
        r = '0;
        for (int k = 0; k < int'(PPC); k++) r[k*24 +: 24] = px_op(m, v, d[k*24 +: 24]);
        return r;
    endfunction

    // Compare process: one pass per cycle at the falling edge, then model update.
    always @(negedge clk) begin
        ofire_eof = 1'b0;
        if (Reset) begin
            chk("in_ready_in_reset", BW'(in_ready), BW'(0));
        end else if (prev_reset) begin
            chk("reset_out_valid", BW'(out_valid), BW'(0));
            chk("reset_out_data", out_data, BW'(0));
            chk("reset_tags", BW'({out_sol, out_eol, out_eof}), BW'(0));
            chk("reset_busy", BW'(busy), BW'(0));
            chk("reset_frame_done", BW'(frame_done), BW'(0));
        end else begin
            chk("busy", BW'(busy), BW'(busy_m));
            chk("frame_done", BW'(frame_done), BW'(done_m));
            chk("in_ready", BW'(in_ready), BW'(!drain_m && (q.size() < 2 || out_ready)));
            if (prev_stall) begin
                chk("stall_valid", BW'(out_valid), BW'(1));
                chk("stall_data", out_data, prev_data);
                chk("stall_tags", BW'({out_sol, out_eol, out_eof}), BW'(prev_tags));
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_beat actual=%0h expected=none", out_data);
                end else begin
                    e = q.pop_front();
                    chk("out_data", out_data, e.data);
                    chk("out_tags", BW'({out_sol, out_eol, out_eof}), BW'(e.tags));
                    if (lat_check) chk("latency", BW'(cyc - e.acc), BW'(2));
                    ofire_eof = e.tags[0];
                end
            end
        end

        if (Reset) begin
            q.delete();
            idx        = 0;
            fmode      = 0;
            fval       = 0;
            busy_m     = 0;
            drain_m    = 0;
            done_m     = 0;
            prev_stall = 0;
        end else begin
            done_m = ofire_eof;
            if (ofire_eof) begin
                busy_m  = 0;
                drain_m = 0;
            end
            if (in_valid && in_ready) begin
                if (idx == 0) begin
                    fmode = int'(mode);
                    fval  = int'(value);
                end
                q.push_back('{data: beat_op(fmode, fval, in_data),
                              tags: {idx % int'(BPL) == 0, idx % int'(BPL) == int'(BPL) - 1,
                                     idx == int'(BPF) - 1},
                              acc:  cyc});
                busy_m = 1;
                if (idx == int'(BPF) - 1) drain_m = 1;
                idx = (idx + 1) % int'(BPF);
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_tags  = {out_sol, out_eol, out_eof};
        end
        prev_reset = Reset;
    end

    // Output-side ready: 0 = always, 1 = random 50%, 2 = held low.
    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'($urandom_range(1, 0));
                default: out_ready = 1'b0;
            endcase
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_beat(input logic [BW-1:0] d, input logic [2:0] m, input logic [DW-1:0] v);
        int n;
        bit acc;
        in_valid = 1'b1;
        in_data  = d;
        mode     = m;
        value    = v;
        n   = 0;
        acc = 0;
        while (!acc && n < 200) begin
            @(negedge clk);
            acc = in_ready;
            tick();
            n++;
        end
        in_valid = 1'b0;
        chk("accept_within_bound", BW'(acc), BW'(1));
    endtask

    function automatic logic [BW-1:0] rand_beat();
        return BW'({$urandom, $urandom, $urandom});
    endfunction

    task automatic send_frame(input int m0, input int v, input bit mix, input int max_gap);
        int m;
        for (int b = 0; b < int'(BPF); b++) begin
            repeat ($urandom_range(max_gap, 0)) tick();
            m = (mix && b > 0) ? int'($urandom_range(7, 0)) : m0;
            drive_beat(rand_beat(), 3'(m), DW'(v));
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((q.size() != 0 || busy) && n < 500) begin
            tick();
            n++;
        end
        chk("drain_within_bound", BW'(n < 500), BW'(1));
        tick();
        tick();
    endtask

    task automatic do_reset(input int cycles);
        Reset    = 1'b1;
        in_valid = 1'b0;
        repeat (cycles) tick();
        Reset = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [BW-1:0] d;
        Reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        mode     = '0;
        value    = '0;

        // Hand-computed pins on the reference rule.
        chk("pin_add_sat", BW'(px_op(1, 'h40, 24'hF010C0)), BW'(24'hFF50FF));
        chk("pin_sub_sat", BW'(px_op(2, 'h40, 24'hF010C0)), BW'(24'hB00080));
        chk("pin_thr_low", BW'(px_op(4, 'h80, 24'h80807F)), BW'(24'h000000));
        chk("pin_thr_high", BW'(px_op(4, 'h80, 24'h808080)), BW'(24'hFFFFFF));
        chk("pin_invert", BW'(px_op(3, 0, 24'h00FF12)), BW'(24'hFF00ED));
        chk("pin_mode7_pass", BW'(px_op(7, 'h33, 24'h123456)), BW'(24'h123456));

        repeat (3) tick();
        Reset = 1'b0;
        tick();

        // Pass-through, back-to-back, two-cycle latency.
        rdy_mode  = 0;
        tick();
        lat_check = 1;
        send_frame(0, 0, 0, 0);
        wait_idle();
        lat_check = 0;

        // Saturating add and subtract on the reference pixel.
        for (int m = 1; m <= 2; m++) begin
            for (int b = 0; b < int'(BPF); b++) begin
                d = rand_beat();
                d[23:0]  = 24'hF010C0;
                d[71:48] = 24'hF010C0;
                drive_beat(d, 3'(m), 8'h40);
            end
            wait_idle();
        end

        // Threshold exactly at and just below 3*value.
        for (int b = 0; b < int'(BPF); b++) begin
            d = {24'h808080, 24'h80807F, (b % 2 == 0) ? 24'h808080 : 24'h80807F};
            drive_beat(d, 3'd4, 8'h80);
        end
        wait_idle();

        // Backpressure: fill both stages with the output stalled.
        rdy_mode = 2;
        tick();
        tick();
        drive_beat(rand_beat(), 3'd3, 8'h00);
        drive_beat(rand_beat(), 3'd3, 8'h00);
        in_valid = 1'b1;
        in_data  = rand_beat();
        @(negedge clk);
        chk("full_in_ready_low", BW'(in_ready), BW'(0));
        chk("full_out_valid", BW'(out_valid), BW'(1));
        tick();
        rdy_mode = 1;
        drive_beat(in_data, 3'd3, 8'h00);
        drive_beat(rand_beat(), 3'd3, 8'h00);
        wait_idle();
        send_frame(1, int'($urandom_range(255, 0)), 0, 0);
        wait_idle();

        // Mid-frame mode change is ignored until the next frame.
        rdy_mode = 0;
        drive_beat(rand_beat(), 3'd3, 8'h00);
        drive_beat(rand_beat(), 3'd3, 8'h00);
        drive_beat(rand_beat(), 3'd0, 8'h00);
        drive_beat(rand_beat(), 3'd0, 8'h00);
        wait_idle();

        // Reset mid-frame with beats in flight, then a clean frame.
        rdy_mode = 1;
        drive_beat(rand_beat(), 3'd2, 8'h10);
        drive_beat(rand_beat(), 3'd2, 8'h10);
        drive_beat(rand_beat(), 3'd2, 8'h10);
        do_reset(1);
        send_frame(3, 0, 0, 0);
        wait_idle();

        // Randomised frames: modes 0-7, random levels, gaps and backpressure.
        for (int f = 0; f < 16; f++) begin
            rdy_mode = int'($urandom_range(1, 0));
            send_frame(int'($urandom_range(7, 0)), int'($urandom_range(255, 0)), 1, 2);
        end
        wait_idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
